// File: rtl/alu_writeback.sv
// alu_writeback: write-back stage behind the 8-bit ALU.
// Captures ALU results into an 8x8 register file plus C/Z flags. A 2-entry
// skid buffer absorbs register-file stalls. The stage also drives the operand
// read ports and the ALU carry-in.
// Optional feature: define ALU_WB_BYPASS_EN to forward pending (uncommitted)
// results onto rs1_data/rs2_data/ci. The default build reads committed state only.

module alu_writeback #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_cout,
   input  logic              wb_zout,
   input  logic              wb_wr_reg,
   input  logic              wb_wr_flags,
   input  logic              rf_stall,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic              ci,
   output logic              flag_c,
   output logic              flag_z
);

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
      logic              cout;
      logic              zout;
      logic              wr_reg;
      logic              wr_flags;
   } entry_t;

   // State
   entry_t            buf_q [2];
   logic              head_q;
   logic [1:0]        count_q;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic              c_q;
   logic              z_q;

   // Next-state / control
   entry_t     in_e;
   entry_t     head_e;
   entry_t     commit_e;
   logic       xfer;
   logic       commit_head;
   logic       commit_direct;
   logic       commit_any;
   logic       enq;
   logic       wr_idx;
   logic       head_d;
   logic [1:0] count_d;

   // Ready depends on registered occupancy and reset only, never on wb_valid.
   assign wb_ready = !rst && (count_q != 2'd2);

   // Pack the incoming result and decide commit/enqueue for this edge.
   always_comb begin
      in_e.dest     = wb_dest;
      in_e.data     = wb_data;
      in_e.cout     = wb_cout;
      in_e.zout     = wb_zout;
      in_e.wr_reg   = wb_wr_reg;
      in_e.wr_flags = wb_wr_flags;

      head_e        = buf_q[head_q];
      xfer          = wb_valid && wb_ready;
      commit_head   = (count_q != 2'd0) && !rf_stall;
      // Empty buffer and no stall: the incoming entry bypasses the buffer.
      commit_direct = (count_q == 2'd0) && xfer && !rf_stall;
      commit_any    = commit_head || commit_direct;
      commit_e      = commit_head ? head_e : in_e;
      enq           = xfer && !commit_direct;

      // Slot after the last valid entry: head when empty, the other slot when one held.
      wr_idx        = head_q ^ count_q[0];
      head_d        = commit_head ? ~head_q : head_q;

      count_d = count_q;
      if (enq && !commit_head) begin
         count_d = count_q + 2'd1;
      end else if (!enq && commit_head) begin
         count_d = count_q - 2'd1;
      end
   end

   // Skid buffer storage and pointers; reset drops every pending entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         head_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (enq) begin
            buf_q[wr_idx] <= in_e;
         end
         head_q  <= head_d;
         count_q <= count_d;
      end
   end

   // Register file and flag commit, at most one entry per edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
         c_q <= 1'b0;
         z_q <= 1'b0;
      end else if (commit_any) begin
         if (commit_e.wr_reg) begin
            regs_q[commit_e.dest] <= commit_e.data;
         end
         if (commit_e.wr_flags) begin
            c_q <= commit_e.cout;
            z_q <= commit_e.zout;
         end
      end
   end

   assign flag_c = c_q;
   assign flag_z = z_q;

`ifdef ALU_WB_BYPASS_EN
   entry_t tail_e;

   // Forward the youngest pending producer; later assignments win, so the
   // order below runs oldest to youngest: regs, head, tail, incoming.
   always_comb begin
      // Tail is the other slot only when both slots are occupied.
      tail_e   = buf_q[head_q ^ count_q[1]];

      rs1_data = regs_q[rs1_addr];
      rs2_data = regs_q[rs2_addr];
      ci       = c_q;

      if (count_q != 2'd0) begin
         if (head_e.wr_reg && head_e.dest == rs1_addr) rs1_data = head_e.data;
         if (head_e.wr_reg && head_e.dest == rs2_addr) rs2_data = head_e.data;
         if (head_e.wr_flags)                          ci       = head_e.cout;
      end
      if (count_q == 2'd2) begin
         if (tail_e.wr_reg && tail_e.dest == rs1_addr) rs1_data = tail_e.data;
         if (tail_e.wr_reg && tail_e.dest == rs2_addr) rs2_data = tail_e.data;
         if (tail_e.wr_flags)                          ci       = tail_e.cout;
      end
      if (xfer) begin
         if (wb_wr_reg && wb_dest == rs1_addr) rs1_data = wb_data;
         if (wb_wr_reg && wb_dest == rs2_addr) rs2_data = wb_data;
         if (wb_wr_flags)                      ci       = wb_cout;
      end
   end
`else
   // Committed state only; upstream holds dependent ops until the buffer drains.
   always_comb begin
      rs1_data = regs_q[rs1_addr];
      rs2_data = regs_q[rs2_addr];
      ci       = c_q;
   end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback. A reference FIFO model receives
// each accepted result when it is driven and releases it at the edge where
// the stage should commit it; read ports and flags are compared against it.

module tb_alu_writeback;

   typedef struct packed {
      logic [2:0] dest;
      logic [7:0] data;
      logic       cout;
      logic       zout;
      logic       wr_reg;
      logic       wr_flags;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wb_valid = 1'b0;
   logic       wb_ready;
   logic [2:0] wb_dest = '0;
   logic [7:0] wb_data = '0;
   logic       wb_cout = 1'b0;
   logic       wb_zout = 1'b0;
   logic       wb_wr_reg = 1'b0;
   logic       wb_wr_flags = 1'b0;
   logic       rf_stall = 1'b0;
   logic [2:0] rs1_addr = '0;
   logic [2:0] rs2_addr = '0;
   logic [7:0] rs1_data;
   logic [7:0] rs2_data;
   logic       ci;
   logic       flag_c;
   logic       flag_z;

   int errors = 0;
   int checks = 0;

   // Reference model
   ent_t       mq[$];
   logic [7:0] mregs [8];
   logic       mc;
   logic       mz;

   always #5 clk = ~clk;

   alu_writeback #(.DATA_W(8), .NREGS(8), .ADDR_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_dest     (wb_dest),
      .wb_data     (wb_data),
      .wb_cout     (wb_cout),
      .wb_zout     (wb_zout),
      .wb_wr_reg   (wb_wr_reg),
      .wb_wr_flags (wb_wr_flags),
      .rf_stall    (rf_stall),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .ci          (ci),
      .flag_c      (flag_c),
      .flag_z      (flag_z)
   );

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
      mc = 1'b0;
      mz = 1'b0;
   endtask

   function automatic logic [7:0] exp_read(input logic [2:0] a);
      logic [7:0] d;
      d = mregs[a];
`ifdef ALU_WB_BYPASS_EN
      foreach (mq[i]) if (mq[i].wr_reg && mq[i].dest == a) d = mq[i].data;
`endif
      return d;
   endfunction

   function automatic logic exp_ci();
      logic c;
      c = mc;
`ifdef ALU_WB_BYPASS_EN
      foreach (mq[i]) if (mq[i].wr_flags) c = mq[i].cout;
`endif
      return c;
   endfunction

   function automatic ent_t mk(input logic [2:0] d, input logic [7:0] v, input logic co,
                               input logic zo, input logic wr, input logic wf);
      ent_t e;
      e.dest = d; e.data = v; e.cout = co; e.zout = zo; e.wr_reg = wr; e.wr_flags = wf;
      return e;
   endfunction

   // One clock: drive inputs, push accepted entry, pop the model head at the edge.
   task automatic step(input ent_t e, input logic v, input logic stall);
      logic acc;
      ent_t h;
      acc         = v && (mq.size() < 2);
      wb_valid    = v;
      wb_dest     = e.dest;
      wb_data     = e.data;
      wb_cout     = e.cout;
      wb_zout     = e.zout;
      wb_wr_reg   = e.wr_reg;
      wb_wr_flags = e.wr_flags;
      rf_stall    = stall;
      @(posedge clk);
      if (acc) mq.push_back(e);
      if (!stall && mq.size() > 0) begin
         h = mq.pop_front();
         if (h.wr_reg) mregs[h.dest] = h.data;
         if (h.wr_flags) begin
            mc = h.cout;
            mz = h.zout;
         end
      end
      #1;
      wb_valid = 1'b0;
      rf_stall = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (wb_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", wb_ready);
      end
      checks++;
      if ({ci, flag_c, flag_z} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b expected 000", {ci, flag_c, flag_z});
      end
      for (int i = 0; i < 8; i++) begin
         rs1_addr = 3'(i);
         #1;
         checks++;
         if (rs1_data !== 8'h00) begin
            errors++; $display("FAIL reset_reg%0d: got %h expected 00", i, rs1_data);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++; $display("FAIL release_ready: got %b expected 1", wb_ready);
      end
   endtask

   task automatic test_basic();
      step(mk(3'd3, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
      rs1_addr = 3'd3;
      #1;
      checks++;
      if (rs1_data !== 8'h5A || rs1_data !== exp_read(3'd3)) begin
         errors++; $display("FAIL basic_r3: got %h expected %h", rs1_data, exp_read(3'd3));
      end
      // Register 0 is an ordinary register.
      step(mk(3'd0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
      rs2_addr = 3'd0;
      #1;
      checks++;
      if (rs2_data !== exp_read(3'd0)) begin
         errors++; $display("FAIL basic_r0: got %h expected %h", rs2_data, exp_read(3'd0));
      end
   endtask

   task automatic test_stall_order();
      step(mk(3'd1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++; $display("FAIL stall_ready1: got %b expected 1", wb_ready);
      end
      step(mk(3'd2, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      checks++;
      if (wb_ready !== 1'b0) begin
         errors++; $display("FAIL stall_full: got %b expected 0", wb_ready);
      end
      rs1_addr = 3'd1; rs2_addr = 3'd2;
      #1;
      checks++;
      if (rs1_data !== exp_read(3'd1) || rs2_data !== exp_read(3'd2)) begin
         errors++; $display("FAIL stall_pending: got %h/%h expected %h/%h",
                            rs1_data, rs2_data, exp_read(3'd1), exp_read(3'd2));
      end
      // A third result offered while full must be refused.
      step(mk(3'd1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      checks++;
      if (rs1_data !== exp_read(3'd1) || rs2_data !== exp_read(3'd2)) begin
         errors++; $display("FAIL order_first: got %h/%h expected %h/%h",
                            rs1_data, rs2_data, exp_read(3'd1), exp_read(3'd2));
      end
      step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      checks++;
      if (rs1_data !== 8'h11 || rs2_data !== 8'h22) begin
         errors++; $display("FAIL order_second: got %h/%h expected 11/22", rs1_data, rs2_data);
      end
   endtask

   task automatic test_bypass();
      step(mk(3'd4, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      rs2_addr = 3'd4;
      #1;
      checks++;
      if (rs2_data !== exp_read(3'd4)) begin
         errors++; $display("FAIL bypass_r4: got %h expected %h", rs2_data, exp_read(3'd4));
      end
      step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      checks++;
      if (rs2_data !== 8'h80) begin
         errors++; $display("FAIL bypass_commit: got %h expected 80", rs2_data);
      end
   endtask

   task automatic test_flags();
      step(mk(3'd3, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0);
      rs1_addr = 3'd3;
      #1;
      checks++;
      if (flag_c !== 1'b1 || flag_z !== 1'b1 || ci !== exp_ci()) begin
         errors++; $display("FAIL flags_set: got c=%b z=%b ci=%b expected 1 1 %b",
                            flag_c, flag_z, ci, exp_ci());
      end
      checks++;
      if (rs1_data !== exp_read(3'd3)) begin
         errors++; $display("FAIL flags_reg: got %h expected %h", rs1_data, exp_read(3'd3));
      end
      step(mk(3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      checks++;
      if (flag_c !== mc || flag_z !== mz || rs1_data !== exp_read(3'd3)) begin
         errors++; $display("FAIL flags_hold: got c=%b z=%b r3=%h expected %b %b %h",
                            flag_c, flag_z, rs1_data, mc, mz, exp_read(3'd3));
      end
   endtask

   task automatic test_same_dest();
      step(mk(3'd5, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      step(mk(3'd5, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
      rs1_addr = 3'd5;
      #1;
      checks++;
      if (rs1_data !== exp_read(3'd5)) begin
         errors++; $display("FAIL samedest_pending: got %h expected %h", rs1_data, exp_read(3'd5));
      end
      step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      checks++;
      if (rs1_data !== 8'h02) begin
         errors++; $display("FAIL samedest_final: got %h expected 02", rs1_data);
      end
   endtask

   task automatic test_back_to_back();
      ent_t e;
      logic v, s, exp_rdy;
      for (int n = 0; n < 60; n++) begin
         e = mk(3'($urandom_range(7)), 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
         v = ($urandom_range(3) != 0);
         s = ($urandom_range(3) == 0);
         exp_rdy = (mq.size() < 2);
         checks++;
         if (wb_ready !== exp_rdy) begin
            errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", n, wb_ready, exp_rdy);
         end
         step(e, v, s);
         rs1_addr = 3'($urandom_range(7));
         rs2_addr = e.dest;
         #1;
         checks++;
         if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr) ||
             flag_c !== mc || flag_z !== mz || ci !== exp_ci()) begin
            errors++;
            $display("FAIL b2b_state[%0d]: got %h %h c=%b z=%b ci=%b expected %h %h %b %b %b",
                     n, rs1_data, rs2_data, flag_c, flag_z, ci, exp_read(rs1_addr),
                     exp_read(rs2_addr), mc, mz, exp_ci());
         end
      end
   endtask

   task automatic test_reset_mid();
      step(mk(3'd6, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 1'b1);
      step(mk(3'd7, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (wb_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_ready: got %b expected 0", wb_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      checks++;
      if (flag_c !== 1'b0 || flag_z !== 1'b0 || ci !== 1'b0 || wb_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_flags: got c=%b z=%b ci=%b rdy=%b expected 0 0 0 1",
                            flag_c, flag_z, ci, wb_ready);
      end
      for (int i = 0; i < 8; i++) begin
         rs1_addr = 3'(i);
         #1;
         checks++;
         if (rs1_data !== 8'h00) begin
            errors++; $display("FAIL midreset_reg%0d: got %h expected 00", i, rs1_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_order();
      test_bypass();
      test_flags();
      test_same_dest();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
